fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the core. It replaces the fixed two-cycle stall FSM and free-running PC with a pipelined fetcher: it issues one word address per cycle to a synchronous instruction memory of configurable read latency and buffers returned words in a prefetch FIFO. It hands instructions to decode over a valid/ready handshake and supports same-cycle-requested PC redirects (branch/jump), which flush all in-flight and buffered fetches.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction-memory request/return, redirect, and the
// valid/ready instruction stream toward decode.
interface fetch_unit_if #(
   parameter int PC_W    = 15,
   parameter int INSTR_W = 32
);
   logic [PC_W-1:0]    imem_addr;
   logic               imem_en;
   logic [INSTR_W-1:0] imem_data;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;

   modport master (
      output imem_addr, imem_en, out_valid, out_instr, out_pc,
      input  imem_data, redirect, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, imem_en, out_valid, out_instr, out_pc,
      output imem_data, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: credit-gated issue to a fixed-latency imem,
// prefetch FIFO toward decode, full flush on redirect.
module fetch_unit #(
   parameter int              PC_W       = 15,
   parameter int              INSTR_W    = 32,
   parameter int              MEM_LAT    = 2,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC   = PC_W'(15'h7FFE)
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]                    fetch_pc_q, fetch_pc_d;
   logic [MEM_LAT-1:0]                 vld_q, vld_d;
   logic [MEM_LAT-1:0][PC_W-1:0]       pc_pipe_q, pc_pipe_d;
   logic [FIFO_DEPTH-1:0][INSTR_W-1:0] fifo_instr_q;
   logic [FIFO_DEPTH-1:0][PC_W-1:0]    fifo_pc_q;
   logic [AW-1:0]                      rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]                      count_q, count_d, inflight;
   logic                               issue, push, pop;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CW'(vld_q[i]);
   end

   assign push  = vld_q[MEM_LAT-1];
   assign pop   = bus.out_valid & bus.out_ready & ~bus.redirect;
   // Each issued word holds a FIFO slot from issue until popped, so a push can never overflow.
   assign issue = ~rst & ~bus.redirect &
                  (((CW+1)'(count_q) + (CW+1)'(inflight)) < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop)));

   assign bus.imem_addr = fetch_pc_q;
   assign bus.imem_en   = issue;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = fifo_instr_q[rd_ptr_q];
   assign bus.out_pc    = fifo_pc_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      vld_d      = vld_q;
      pc_pipe_d  = pc_pipe_q;
      count_d    = count_q;
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_pc;
         vld_d      = '0;
         count_d    = '0;
      end else begin
         for (int i = MEM_LAT - 1; i > 0; i--) begin
            vld_d[i]     = vld_q[i-1];
            pc_pipe_d[i] = pc_pipe_q[i-1];
         end
         vld_d[0]     = issue;
         pc_pipe_d[0] = fetch_pc_q;
         if (issue) fetch_pc_d = fetch_pc_q + PC_W'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         vld_q        <= '0;
         pc_pipe_q    <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         fifo_instr_q <= '0;
         fifo_pc_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         vld_q      <= vld_d;
         pc_pipe_q  <= pc_pipe_d;
         count_q    <= count_d;
         if (bus.redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) begin
               assert (count_q < CW'(FIFO_DEPTH));
               fifo_instr_q[wr_ptr_q] <= bus.imem_data;
               fifo_pc_q[wr_ptr_q]    <= pc_pipe_q[MEM_LAT-1];
               wr_ptr_q               <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Four fetch_unit configurations share one stimulus stream; each has its own
// fixed-latency memory and is checked against arithmetic expectations.
module tb_fetch_unit;
   localparam int N = 4;
   localparam int LATS [N] = '{2, 1, 4, 3};
   localparam int DEPS [N] = '{4, 4, 8, 4};
   localparam logic [14:0] RPC = 15'h7FFE;

   logic        clk, rst, redirect, out_ready;
   logic [14:0] redirect_pc;
   wire         ov_w   [N];
   wire         en_w   [N];
   wire  [14:0] addr_w [N];
   wire  [14:0] opc_w  [N];
   wire  [31:0] ins_w  [N];
   int total = 0, bad = 0;

   function automatic logic [31:0] mdat(input logic [14:0] a);
      return {a, 2'b10, ~a} ^ 32'h5A5A_3C3C;
   endfunction

   // Ready-held stream that starts issuing at cycle fi from pc start.
   function automatic void exp_stream(input int lat, input int fi, input logic [14:0] start,
                                      input int c, output logic v, output logic [14:0] pc);
      v  = (c >= fi + lat + 1);
      pc = start + 15'(c - fi - lat - 1);
   endfunction

   for (genvar g = 0; g < N; g++) begin : gd
      localparam int L = LATS[g];
      fetch_unit_if #(.PC_W(15), .INSTR_W(32)) bus ();
      logic [L-1:0]       mv = '0;
      logic [L-1:0][14:0] ma = '0;
      assign bus.redirect    = redirect;
      assign bus.redirect_pc = redirect_pc;
      assign bus.out_ready   = out_ready;
      assign bus.imem_data   = mv[L-1] ? mdat(ma[L-1]) : 32'h0BAD_F00D;
      always @(posedge clk) begin
         mv[0] <= bus.imem_en;
         ma[0] <= bus.imem_addr;
         for (int k = 1; k < L; k++) begin
            mv[k] <= mv[k-1];
            ma[k] <= ma[k-1];
         end
      end
      assign ov_w[g]   = bus.out_valid;
      assign en_w[g]   = bus.imem_en;
      assign addr_w[g] = bus.imem_addr;
      assign opc_w[g]  = bus.out_pc;
      assign ins_w[g]  = bus.out_instr;
      fetch_unit #(.PC_W(15), .INSTR_W(32), .MEM_LAT(LATS[g]), .FIFO_DEPTH(DEPS[g]),
                   .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1; redirect = 1'b0; out_ready = 1'b0; redirect_pc = '0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         total++; if (ov_w[i] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d got=%b want=0", i, ov_w[i]); end
         total++; if (en_w[i] !== 1'b0) begin bad++; $display("FAIL reset_en dut%0d got=%b want=0", i, en_w[i]); end
         total++; if (addr_w[i] !== RPC) begin bad++; $display("FAIL reset_addr dut%0d got=%h want=%h", i, addr_w[i], RPC); end
         total++; if (ins_w[i] !== 32'h0) begin bad++; $display("FAIL reset_instr dut%0d got=%h want=0", i, ins_w[i]); end
         total++; if (opc_w[i] !== 15'h0) begin bad++; $display("FAIL reset_pc dut%0d got=%h want=0", i, opc_w[i]); end
      end
   endtask

   task automatic test_stream();
      logic v; logic [14:0] p;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         tick(); rst = 1'b0; out_ready = 1'b1; redirect = 1'b0; #1;
         for (int i = 0; i < N; i++) begin
            exp_stream(LATS[i], 0, RPC, c, v, p);
            total++; if (en_w[i] !== 1'b1 || addr_w[i] !== RPC + 15'(c)) begin bad++;
               $display("FAIL stream_issue dut%0d c%0d got=%b/%h want=1/%h", i, c, en_w[i], addr_w[i], RPC + 15'(c)); end
            total++; if (ov_w[i] !== v) begin bad++; $display("FAIL stream_valid dut%0d c%0d got=%b want=%b", i, c, ov_w[i], v); end
            if (v) begin
               total++; if (opc_w[i] !== p || ins_w[i] !== mdat(p)) begin bad++;
                  $display("FAIL stream_data dut%0d c%0d got=%h/%h want=%h/%h", i, c, opc_w[i], ins_w[i], p, mdat(p)); end
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [14:0] p;
      do_reset();
      for (int c = 0; c < 23; c++) begin
         tick(); rst = 1'b0; redirect = 1'b0; out_ready = (c >= 10); #1;
         for (int i = 0; i < N; i++) begin
            if (c < 10) begin
               total++; if (en_w[i] !== (c < DEPS[i])) begin bad++;
                  $display("FAIL stall_en dut%0d c%0d got=%b want=%b", i, c, en_w[i], c < DEPS[i]); end
               total++; if (ov_w[i] !== (c >= LATS[i] + 1)) begin bad++;
                  $display("FAIL stall_valid dut%0d c%0d got=%b want=%b", i, c, ov_w[i], c >= LATS[i] + 1); end
               if (c >= LATS[i] + 1) begin
                  total++; if (opc_w[i] !== RPC) begin bad++; $display("FAIL stall_head dut%0d c%0d got=%h want=%h", i, c, opc_w[i], RPC); end
               end
            end else begin
               p = RPC + 15'(c - 10);
               total++; if (en_w[i] !== 1'b1) begin bad++; $display("FAIL release_en dut%0d c%0d got=%b want=1", i, c, en_w[i]); end
               total++; if (ov_w[i] !== 1'b1 || opc_w[i] !== p || ins_w[i] !== mdat(p)) begin bad++;
                  $display("FAIL release_data dut%0d c%0d got=%b/%h/%h want=1/%h/%h", i, c, ov_w[i], opc_w[i], ins_w[i], p, mdat(p)); end
            end
         end
      end
   endtask

   // Redirect at c=r0 to pc0; optional second redirect at r0+1 to pc1.
   task automatic test_redirect(input bit two, input logic [14:0] pc0, input logic [14:0] pc1);
      localparam int R0 = 5;
      logic v, ee; logic [14:0] p, ea, tgt;
      int fi;
      fi  = two ? R0 + 2 : R0 + 1;
      tgt = two ? pc1 : pc0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         tick(); rst = 1'b0; out_ready = 1'b1;
         redirect    = (c == R0) || (two && c == R0 + 1);
         redirect_pc = (c == R0) ? pc0 : pc1;
         #1;
         ee = !(c >= R0 && c < fi);
         ea = (c <= R0) ? RPC + 15'(c) : (c < fi) ? pc0 : tgt + 15'(c - fi);
         for (int i = 0; i < N; i++) begin
            if (c <= R0) exp_stream(LATS[i], 0, RPC, c, v, p);
            else         exp_stream(LATS[i], fi, tgt, c, v, p);
            total++; if (en_w[i] !== ee || addr_w[i] !== ea) begin bad++;
               $display("FAIL redir_issue dut%0d c%0d got=%b/%h want=%b/%h", i, c, en_w[i], addr_w[i], ee, ea); end
            total++; if (ov_w[i] !== v) begin bad++; $display("FAIL redir_valid dut%0d c%0d got=%b want=%b", i, c, ov_w[i], v); end
            if (v) begin
               total++; if (opc_w[i] !== p || ins_w[i] !== mdat(p)) begin bad++;
                  $display("FAIL redir_data dut%0d c%0d got=%h/%h want=%h/%h", i, c, opc_w[i], ins_w[i], p, mdat(p)); end
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic v; logic [14:0] p;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         tick(); rst = 1'b0; out_ready = 1'b1; redirect = 1'b0; #1;
      end
      tick(); rst = 1'b1; #1;
      for (int i = 0; i < N; i++) begin
         total++; if (en_w[i] !== 1'b0) begin bad++; $display("FAIL midrst_en dut%0d got=%b want=0", i, en_w[i]); end
      end
      for (int c = 0; c < 12; c++) begin
         tick(); rst = 1'b0; #1;
         for (int i = 0; i < N; i++) begin
            exp_stream(LATS[i], 0, RPC, c, v, p);
            if (c == 0) begin
               total++; if (ins_w[i] !== 32'h0 || opc_w[i] !== 15'h0 || addr_w[i] !== RPC) begin bad++;
                  $display("FAIL midrst_vals dut%0d got=%h/%h/%h want=0/0/%h", i, ins_w[i], opc_w[i], addr_w[i], RPC); end
            end
            total++; if (ov_w[i] !== v) begin bad++; $display("FAIL midrst_valid dut%0d c%0d got=%b want=%b", i, c, ov_w[i], v); end
            if (v) begin
               total++; if (opc_w[i] !== p || ins_w[i] !== mdat(p)) begin bad++;
                  $display("FAIL midrst_data dut%0d c%0d got=%h/%h want=%h/%h", i, c, opc_w[i], ins_w[i], p, mdat(p)); end
            end
         end
      end
   endtask

   // Scoreboard: issue addresses and delivered pcs each form a sequence restarted
   // by redirect; outstanding (issued, not popped) words never exceed the FIFO depth.
   task automatic test_random();
      logic [14:0] nxt [N];
      logic [14:0] expc [N];
      int held [N];
      int npop [N];
      logic prev_redir, pop, cred;
      do_reset();
      for (int i = 0; i < N; i++) begin nxt[i] = RPC; expc[i] = RPC; held[i] = 0; npop[i] = 0; end
      prev_redir = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         tick();
         rst         = 1'b0;
         out_ready   = ($urandom_range(0, 99) < 65);
         redirect    = ($urandom_range(0, 99) < 3);
         redirect_pc = ($urandom_range(0, 3) == 0) ? 15'h7FFC + 15'($urandom_range(0, 3)) : 15'($urandom);
         #1;
         for (int i = 0; i < N; i++) begin
            pop = ov_w[i] && out_ready && !redirect;
            if (prev_redir) begin
               total++; if (ov_w[i] !== 1'b0) begin bad++; $display("FAIL rnd_flush dut%0d c%0d got=%b want=0", i, c, ov_w[i]); end
            end
            if (redirect) begin
               total++; if (en_w[i] !== 1'b0) begin bad++; $display("FAIL rnd_redir_en dut%0d c%0d got=%b want=0", i, c, en_w[i]); end
            end else begin
               cred = (held[i] - int'(pop)) < DEPS[i];
               total++; if (en_w[i] !== cred) begin bad++;
                  $display("FAIL rnd_credit dut%0d c%0d got=%b want=%b held=%0d", i, c, en_w[i], cred, held[i]); end
               if (en_w[i] === 1'b1) begin
                  total++; if (addr_w[i] !== nxt[i]) begin bad++;
                     $display("FAIL rnd_addr dut%0d c%0d got=%h want=%h", i, c, addr_w[i], nxt[i]); end
               end
            end
            if (pop) begin
               total++; if (opc_w[i] !== expc[i] || ins_w[i] !== mdat(expc[i])) begin bad++;
                  $display("FAIL rnd_data dut%0d c%0d got=%h/%h want=%h/%h", i, c, opc_w[i], ins_w[i], expc[i], mdat(expc[i])); end
            end
            if (redirect) begin
               nxt[i] = redirect_pc; expc[i] = redirect_pc; held[i] = 0;
            end else begin
               if (pop) begin expc[i] = expc[i] + 15'd1; held[i]--; npop[i]++; end
               if (en_w[i] === 1'b1) begin nxt[i] = nxt[i] + 15'd1; held[i]++; end
            end
         end
         prev_redir = redirect;
      end
      for (int i = 0; i < N; i++) begin
         total++; if (npop[i] < 1500) begin bad++; $display("FAIL rnd_progress dut%0d got=%0d want>=1500", i, npop[i]); end
      end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; out_ready = 1'b0; redirect_pc = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect(1'b0, 15'h0100, 15'h0000);
      test_redirect(1'b1, 15'h0200, 15'h7FFF);
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
